hci_log_bank_adapter: RTL and testbench
=======================================

HCI_LOG_BANK_ADAPTER -- requirements
Module: hci_log_bank_adapter

Interface
REQ-001 SHALL have parameter N_MEM, default 32: number of banks handled.
REQ-002 SHALL have parameter AWM, default 12: bank word-address width.
REQ-003 SHALL have parameter DW, default 32: data width.
REQ-004 SHALL have parameter BW, default 8: byte width; byte-enable width is DW/BW.
REQ-005 SHALL have parameter IW, default 20: request ID width.
REQ-006 SHALL have parameter MEM_LAT, default 1, legal 1..4: memory read latency in cycles.
REQ-007 SHALL have one clock and a synchronous active-high reset: clk_i  in  1  clock; rst_i  in  1  synchronous active-high reset.
REQ-008 SHALL have the crossbar-side ports below, each an N_MEM array:
- xb_req_i  in  1  request
- xb_ts_i  in  1  test-and-set flag
- xb_add_i  in  AWM  word address
- xb_wen_i  in  1  1=read, 0=write
- xb_wdata_i  in  DW  write data
- xb_be_i  in  DW/BW  byte enables
- xb_id_i  in  IW  request ID
- xb_gnt_o  out  1  grant
- xb_r_valid_o  out  1  response valid
- xb_r_data_o  out  DW  read data
- xb_r_id_o  out  IW  response ID
REQ-009 SHALL have the memory-side ports below, each an N_MEM array:
- mem_req_o  out  1  request
- mem_add_o  out  AWM  address
- mem_wen_o  out  1  1=read
- mem_wdata_o  out  DW  write data
- mem_be_o  out  DW/BW  byte enables
- mem_gnt_i  in  1  grant
- mem_r_data_i  in  DW  read data, valid MEM_LAT cycles after an accepted read
REQ-010 SHALL have stats_o  out  N_MEM x 16  per-bank conflict count.

Function
REQ-011 Each bank SHALL have an FSM with states IDLE, TS_WRITE.
REQ-012 In IDLE: mem_req_o/add/wen/wdata/be SHALL equal xb_* combinationally; xb_gnt_o = mem_gnt_i.
REQ-013 Accepted access (mem_req_o & mem_gnt_i) from crossbar SHALL push {valid, id} into a MEM_LAT-deep shift pipeline; the slot SHALL emerge as xb_r_valid_o/xb_r_id_o exactly MEM_LAT cycles later, for reads and writes alike.
REQ-014 xb_r_data_o SHALL equal mem_r_data_i.
REQ-015 Accepted read with xb_ts_i=1 in IDLE SHALL move FSM to TS_WRITE on the next cycle, latching the address.
REQ-016 In TS_WRITE: mem_req_o=1, mem_wen_o=0, mem_add_o=latched address, mem_wdata_o=all ones, mem_be_o=all ones, xb_gnt_o=0; FSM SHALL return to IDLE on the cycle after mem_gnt_i=1.
REQ-017 The TS_WRITE access SHALL NOT push a response; the TS read phase SHALL produce exactly one response carrying the old data.
REQ-018 xb_ts_i with xb_wen_i=0 SHALL be treated as a plain write.
REQ-019 Crossbar requests arriving during TS_WRITE SHALL stall (no grant) and are served in IDLE.
REQ-020 Back-to-back accepted accesses SHALL each produce one response, one per cycle, in order.

Reset
REQ-021 On rst_i: FSM=IDLE, pipeline valid bits 0, r_id 0, latched address 0, stats 0.
REQ-022 Reset-driven outputs SHALL follow REQ-012 with the pipeline empty: xb_r_valid_o=0, xb_r_id_o=0.
REQ-023 Reset during TS_WRITE SHALL abort the pending write; no write is issued the cycle after reset.

Configuration
REQ-024 With HCI_LOG_BANK_STATS_EN defined, each bank SHALL count cycles with xb_req_i=1 & xb_gnt_o=0 in a 16-bit saturating counter (holds at 0xFFFF) on stats_o.
REQ-025 Without HCI_LOG_BANK_STATS_EN, stats_o SHALL be tied to 0 and no counter logic is synthesised.

Structure
REQ-026 The FSM state enum and the MEM_LAT legal range SHALL live in hci_package.
REQ-027 The per-bank logic SHALL be sub-module hci_log_bank_ctrl, instantiated N_MEM times.

Verification
REQ-028 Read, MEM_LAT=2, id=0x5, gnt=1 at cycle 0 -> r_valid=1, r_id=0x5 at cycle 2, r_data = mem data.
REQ-029 TS read at addr 0x10 with mem word 0x0 -> response data 0x0; next cycle write 0xFFFFFFFF to 0x10 with be=0xF; a second TS read returns 0xFFFFFFFF.
REQ-030 TS_WRITE with mem_gnt_i held 0 for 3 cycles -> xb_gnt_o=0 for those cycles, new request granted only after return to IDLE.
REQ-031 Four back-to-back writes with ids 1..4, MEM_LAT=1 -> r_valid on 4 consecutive cycles with ids 1,2,3,4.
REQ-032 rst_i asserted in TS_WRITE -> next cycle mem_req_o follows xb_req_i, no all-ones write.
REQ-033 STATS_EN: req held with gnt=0 for 70000 cycles -> stats_o=0xFFFF; without macro -> stats_o=0.

Source files
------------

// File: rtl/hci_package.sv
// Shared types and limits for the HCI log-bank adapter: the per-bank FSM state
// and the legal memory read latency range.
package hci_package;

   typedef enum logic [0:0] {
      StIdle,
      StTsWrite
   } bank_state_e;

   localparam int unsigned MEM_LAT_MIN = 1;
   localparam int unsigned MEM_LAT_MAX = 4;
   localparam int unsigned STATS_W     = 16;

endpackage

// File: rtl/hci_log_bank_ctrl.sv
// Per-bank controller: passes crossbar accesses to memory, tracks responses in a
// MEM_LAT-deep pipeline and inserts the all-ones write of a test-and-set.
// Optional conflict counter enabled by HCI_LOG_BANK_STATS_EN.
module hci_log_bank_ctrl
   import hci_package::*;
#(
   parameter int unsigned AWM     = 12,
   parameter int unsigned DW      = 32,
   parameter int unsigned BW      = 8,
   parameter int unsigned IW      = 20,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               xb_req_i,
   input  logic               xb_ts_i,
   input  logic [AWM-1:0]     xb_add_i,
   input  logic               xb_wen_i,
   input  logic [DW-1:0]      xb_wdata_i,
   input  logic [DW/BW-1:0]   xb_be_i,
   input  logic [IW-1:0]      xb_id_i,
   output logic               xb_gnt_o,
   output logic               xb_r_valid_o,
   output logic [DW-1:0]      xb_r_data_o,
   output logic [IW-1:0]      xb_r_id_o,
   output logic               mem_req_o,
   output logic [AWM-1:0]     mem_add_o,
   output logic               mem_wen_o,
   output logic [DW-1:0]      mem_wdata_o,
   output logic [DW/BW-1:0]   mem_be_o,
   input  logic               mem_gnt_i,
   input  logic [DW-1:0]      mem_r_data_i,
   output logic [STATS_W-1:0] stats_o
);

   bank_state_e    r_state;
   logic [AWM-1:0] r_add;
   logic           r_vld [MEM_LAT];
   logic [IW-1:0]  r_id  [MEM_LAT];
   logic           w_acc;

   always_comb begin
      mem_req_o   = xb_req_i;
      mem_add_o   = xb_add_i;
      mem_wen_o   = xb_wen_i;
      mem_wdata_o = xb_wdata_i;
      mem_be_o    = xb_be_i;
      xb_gnt_o    = mem_gnt_i;
      if (r_state == StTsWrite) begin
         mem_req_o   = 1'b1;
         mem_add_o   = r_add;
         mem_wen_o   = 1'b0;
         mem_wdata_o = '1;
         mem_be_o    = '1;
         xb_gnt_o    = 1'b0;
      end
   end

   // Only crossbar-originated accesses are tracked; the TS write is silent.
   assign w_acc = (r_state == StIdle) && xb_req_i && mem_gnt_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= StIdle;
         r_add   <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_acc && xb_wen_i && xb_ts_i) begin
                  r_state <= StTsWrite;
                  r_add   <= xb_add_i;
               end
            end
            StTsWrite: begin
               if (mem_gnt_i) r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(MEM_LAT); i++) begin
            r_vld[i] <= 1'b0;
            r_id[i]  <= '0;
         end
      end else begin
         r_vld[0] <= w_acc;
         r_id[0]  <= w_acc ? xb_id_i : '0;
         for (int i = 1; i < int'(MEM_LAT); i++) begin
            r_vld[i] <= r_vld[i-1];
            r_id[i]  <= r_id[i-1];
         end
      end
   end

   assign xb_r_valid_o = r_vld[MEM_LAT-1];
   assign xb_r_id_o    = r_id[MEM_LAT-1];
   assign xb_r_data_o  = mem_r_data_i;

`ifdef HCI_LOG_BANK_STATS_EN
   logic [STATS_W-1:0] r_stats;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_stats <= '0;
      end else if (xb_req_i && !xb_gnt_o && (r_stats != '1)) begin
         r_stats <= r_stats + 1'b1;
      end
   end

   assign stats_o = r_stats;
`else
   assign stats_o = '0;
`endif

endmodule

// File: rtl/hci_log_bank_adapter.sv
// Crossbar-to-memory adapter for N_MEM log-interconnect banks with test-and-set
// support. Per-bank conflict statistics are built only with HCI_LOG_BANK_STATS_EN.
module hci_log_bank_adapter
   import hci_package::*;
#(
   parameter int unsigned N_MEM   = 32,
   parameter int unsigned AWM     = 12,
   parameter int unsigned DW      = 32,
   parameter int unsigned BW      = 8,
   parameter int unsigned IW      = 20,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               xb_req_i     [N_MEM],
   input  logic               xb_ts_i      [N_MEM],
   input  logic [AWM-1:0]     xb_add_i     [N_MEM],
   input  logic               xb_wen_i     [N_MEM],
   input  logic [DW-1:0]      xb_wdata_i   [N_MEM],
   input  logic [DW/BW-1:0]   xb_be_i      [N_MEM],
   input  logic [IW-1:0]      xb_id_i      [N_MEM],
   output logic               xb_gnt_o     [N_MEM],
   output logic               xb_r_valid_o [N_MEM],
   output logic [DW-1:0]      xb_r_data_o  [N_MEM],
   output logic [IW-1:0]      xb_r_id_o    [N_MEM],
   output logic               mem_req_o    [N_MEM],
   output logic [AWM-1:0]     mem_add_o    [N_MEM],
   output logic               mem_wen_o    [N_MEM],
   output logic [DW-1:0]      mem_wdata_o  [N_MEM],
   output logic [DW/BW-1:0]   mem_be_o     [N_MEM],
   input  logic               mem_gnt_i    [N_MEM],
   input  logic [DW-1:0]      mem_r_data_i [N_MEM],
   output logic [STATS_W-1:0] stats_o      [N_MEM]
);

   if ((MEM_LAT < MEM_LAT_MIN) || (MEM_LAT > MEM_LAT_MAX)) begin : g_bad_mem_lat
      $error("hci_log_bank_adapter: MEM_LAT out of range");
   end

   for (genvar g = 0; g < int'(N_MEM); g++) begin : g_bank
      hci_log_bank_ctrl #(
         .AWM     (AWM),
         .DW      (DW),
         .BW      (BW),
         .IW      (IW),
         .MEM_LAT (MEM_LAT)
      ) u_ctrl (
         .clk_i        (clk_i),
         .rst_i        (rst_i),
         .xb_req_i     (xb_req_i[g]),
         .xb_ts_i      (xb_ts_i[g]),
         .xb_add_i     (xb_add_i[g]),
         .xb_wen_i     (xb_wen_i[g]),
         .xb_wdata_i   (xb_wdata_i[g]),
         .xb_be_i      (xb_be_i[g]),
         .xb_id_i      (xb_id_i[g]),
         .xb_gnt_o     (xb_gnt_o[g]),
         .xb_r_valid_o (xb_r_valid_o[g]),
         .xb_r_data_o  (xb_r_data_o[g]),
         .xb_r_id_o    (xb_r_id_o[g]),
         .mem_req_o    (mem_req_o[g]),
         .mem_add_o    (mem_add_o[g]),
         .mem_wen_o    (mem_wen_o[g]),
         .mem_wdata_o  (mem_wdata_o[g]),
         .mem_be_o     (mem_be_o[g]),
         .mem_gnt_i    (mem_gnt_i[g]),
         .mem_r_data_i (mem_r_data_i[g]),
         .stats_o      (stats_o[g])
      );
   end

endmodule

// File: tb/tb_hci_log_bank_adapter.sv
// Directed bench for hci_log_bank_adapter: two instances (MEM_LAT 1 and 2) share
// the same crossbar stimulus and a small byte-enabled memory model on bank 0.
module tb_hci_log_bank_adapter;

   localparam int unsigned N   = 2;
   localparam int unsigned AWM = 12;
   localparam int unsigned DW  = 32;
   localparam int unsigned BW  = 8;
   localparam int unsigned BEW = DW / BW;
   localparam int unsigned IW  = 20;

   logic clk, rst;

   logic           xb_req   [N];
   logic           xb_ts    [N];
   logic [AWM-1:0] xb_add   [N];
   logic           xb_wen   [N];
   logic [DW-1:0]  xb_wdata [N];
   logic [BEW-1:0] xb_be    [N];
   logic [IW-1:0]  xb_id    [N];
   logic           mem_gnt  [N];

   logic           d1_xb_gnt [N], d2_xb_gnt [N];
   logic           d1_rvalid [N], d2_rvalid [N];
   logic [DW-1:0]  d1_rdata  [N], d2_rdata  [N];
   logic [IW-1:0]  d1_rid    [N], d2_rid    [N];
   logic           d1_mreq   [N], d2_mreq   [N];
   logic [AWM-1:0] d1_madd   [N], d2_madd   [N];
   logic           d1_mwen   [N], d2_mwen   [N];
   logic [DW-1:0]  d1_mwdata [N], d2_mwdata [N];
   logic [BEW-1:0] d1_mbe    [N], d2_mbe    [N];
   logic [15:0]    d1_stats  [N], d2_stats  [N];
   logic [DW-1:0]  rdata1    [N], rdata2    [N];

   int n_cmp = 0;
   int n_err = 0;

   hci_log_bank_adapter #(
      .N_MEM(N), .AWM(AWM), .DW(DW), .BW(BW), .IW(IW), .MEM_LAT(1)
   ) u_dut (
      .clk_i(clk), .rst_i(rst),
      .xb_req_i(xb_req), .xb_ts_i(xb_ts), .xb_add_i(xb_add), .xb_wen_i(xb_wen),
      .xb_wdata_i(xb_wdata), .xb_be_i(xb_be), .xb_id_i(xb_id),
      .xb_gnt_o(d1_xb_gnt), .xb_r_valid_o(d1_rvalid), .xb_r_data_o(d1_rdata),
      .xb_r_id_o(d1_rid), .mem_req_o(d1_mreq), .mem_add_o(d1_madd), .mem_wen_o(d1_mwen),
      .mem_wdata_o(d1_mwdata), .mem_be_o(d1_mbe), .mem_gnt_i(mem_gnt),
      .mem_r_data_i(rdata1), .stats_o(d1_stats)
   );

   hci_log_bank_adapter #(
      .N_MEM(N), .AWM(AWM), .DW(DW), .BW(BW), .IW(IW), .MEM_LAT(2)
   ) u_dut_lat2 (
      .clk_i(clk), .rst_i(rst),
      .xb_req_i(xb_req), .xb_ts_i(xb_ts), .xb_add_i(xb_add), .xb_wen_i(xb_wen),
      .xb_wdata_i(xb_wdata), .xb_be_i(xb_be), .xb_id_i(xb_id),
      .xb_gnt_o(d2_xb_gnt), .xb_r_valid_o(d2_rvalid), .xb_r_data_o(d2_rdata),
      .xb_r_id_o(d2_rid), .mem_req_o(d2_mreq), .mem_add_o(d2_madd), .mem_wen_o(d2_mwen),
      .mem_wdata_o(d2_mwdata), .mem_be_o(d2_mbe), .mem_gnt_i(mem_gnt),
      .mem_r_data_i(rdata2), .stats_o(d2_stats)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bank 0 memory model: reads return data one cycle later (two for the lat-2 copy).
   logic [DW-1:0] mem [256];
   logic [DW-1:0] rd_p0, rd_p1;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) mem[i] <= (i == 8'h55) ? 32'hA5A5_1234 : 32'h0;
         rd_p0 <= '0;
         rd_p1 <= '0;
      end else begin
         rd_p1 <= rd_p0;
         rd_p0 <= '0;
         if (d1_mreq[0] && mem_gnt[0]) begin
            if (d1_mwen[0]) begin
               rd_p0 <= mem[d1_madd[0][7:0]];
            end else begin
               for (int b = 0; b < int'(BEW); b++)
                  if (d1_mbe[0][b]) mem[d1_madd[0][7:0]][8*b +: 8] <= d1_mwdata[0][8*b +: 8];
            end
         end
      end
   end

   assign rdata1[0] = rd_p0;
   assign rdata2[0] = rd_p1;
   assign rdata1[1] = 32'h0;
   assign rdata2[1] = 32'h0;

   typedef struct {
      logic           req, ts, wen;
      logic [AWM-1:0] add;
      logic [DW-1:0]  wdata;
      logic [BEW-1:0] be;
      logic [IW-1:0]  id;
      logic           gnt;
      logic           e_req, e_wen;
      logic [AWM-1:0] e_add;
      logic [DW-1:0]  e_wdata;
      logic [BEW-1:0] e_be;
      logic           e_gnt;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic drive(input logic req, input logic ts, input logic wen,
                        input logic [AWM-1:0] add, input logic [DW-1:0] wdata,
                        input logic [BEW-1:0] be, input logic [IW-1:0] id, input logic gnt);
      xb_req[0] = req;  xb_ts[0] = ts;   xb_wen[0] = wen; xb_add[0] = add;
      xb_wdata[0] = wdata; xb_be[0] = be; xb_id[0] = id;  mem_gnt[0] = gnt;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < int'(N); i++) begin
         xb_req[i] = 0; xb_ts[i] = 0; xb_add[i] = '0; xb_wen[i] = 0;
         xb_wdata[i] = '0; xb_be[i] = '0; xb_id[i] = '0; mem_gnt[i] = 0;
      end
      //          req ts wen add     wdata          be    id gnt | e_req e_wen e_add  e_wdata      e_be  e_gnt
      vecs[0] = '{1, 0, 1, 12'h001, 32'h0,         4'hF, 1, 1,   1, 1, 12'h001, 32'h0,         4'hF, 1};
      vecs[1] = '{1, 0, 0, 12'h0A5, 32'hDEADBEEF,  4'h5, 2, 0,   1, 0, 12'h0A5, 32'hDEADBEEF,  4'h5, 0};
      vecs[2] = '{0, 0, 1, 12'hFFF, 32'h12345678,  4'hA, 3, 1,   0, 1, 12'hFFF, 32'h12345678,  4'hA, 1};
      vecs[3] = '{1, 1, 0, 12'h020, 32'hCAFEF00D,  4'h3, 4, 1,   1, 0, 12'h020, 32'hCAFEF00D,  4'h3, 1};
      vecs[4] = '{1, 1, 1, 12'h030, 32'h0,         4'hF, 5, 0,   1, 1, 12'h030, 32'h0,         4'hF, 0};
      vecs[5] = '{1, 0, 1, 12'h040, 32'h0,         4'hF, 6, 1,   1, 1, 12'h040, 32'h0,         4'hF, 1};

      rst = 1;
      repeat (3) tick();
      rst = 0;
      mid();
      chk("reset_rvalid", 32'(d1_rvalid[0]), 32'h0);
      chk("reset_rid", 32'(d1_rid[0]), 32'h0);
      chk("reset_rvalid_lat2", 32'(d2_rvalid[0]), 32'h0);
      chk("reset_stats", 32'(d1_stats[0]), 32'h0);
      chk("reset_mem_req", 32'(d1_mreq[0]), 32'h0);

      // IDLE pass-through table, including TS-with-write and ungranted TS read.
      for (int i = 0; i < 6; i++) begin
         tick();
         drive(vecs[i].req, vecs[i].ts, vecs[i].wen, vecs[i].add, vecs[i].wdata,
               vecs[i].be, vecs[i].id, vecs[i].gnt);
         mid();
         chk($sformatf("vec%0d_mem_req", i), 32'(d1_mreq[0]), 32'(vecs[i].e_req));
         chk($sformatf("vec%0d_mem_wen", i), 32'(d1_mwen[0]), 32'(vecs[i].e_wen));
         chk($sformatf("vec%0d_mem_add", i), 32'(d1_madd[0]), 32'(vecs[i].e_add));
         chk($sformatf("vec%0d_mem_wdata", i), d1_mwdata[0], vecs[i].e_wdata);
         chk($sformatf("vec%0d_mem_be", i), 32'(d1_mbe[0]), 32'(vecs[i].e_be));
         chk($sformatf("vec%0d_xb_gnt", i), 32'(d1_xb_gnt[0]), 32'(vecs[i].e_gnt));
      end
      tick();
      drive(0, 0, 0, '0, '0, '0, '0, 0);
      repeat (3) tick();

      // Read latency on both instances.
      drive(1, 0, 1, 12'h055, '0, 4'hF, 20'h5, 1);
      mid();
      chk("lat_gnt", 32'(d1_xb_gnt[0]), 32'h1);
      tick();
      drive(0, 0, 0, '0, '0, '0, '0, 1);
      mid();
      chk("lat1_rvalid", 32'(d1_rvalid[0]), 32'h1);
      chk("lat1_rid", 32'(d1_rid[0]), 32'h5);
      chk("lat1_rdata", d1_rdata[0], 32'hA5A5_1234);
      chk("lat2_rvalid_early", 32'(d2_rvalid[0]), 32'h0);
      tick();
      mid();
      chk("lat2_rvalid", 32'(d2_rvalid[0]), 32'h1);
      chk("lat2_rid", 32'(d2_rid[0]), 32'h5);
      chk("lat2_rdata", d2_rdata[0], 32'hA5A5_1234);
      chk("lat1_rvalid_once", 32'(d1_rvalid[0]), 32'h0);
      tick();

      // Test-and-set: old data returned, then all-ones write, then new value.
      drive(1, 1, 1, 12'h010, '0, 4'hF, 20'h7, 1);
      tick();
      drive(0, 0, 0, '0, '0, '0, '0, 1);
      mid();
      chk("ts_wr_req", 32'(d1_mreq[0]), 32'h1);
      chk("ts_wr_wen", 32'(d1_mwen[0]), 32'h0);
      chk("ts_wr_add", 32'(d1_madd[0]), 32'h010);
      chk("ts_wr_wdata", d1_mwdata[0], 32'hFFFF_FFFF);
      chk("ts_wr_be", 32'(d1_mbe[0]), 32'hF);
      chk("ts_wr_gnt", 32'(d1_xb_gnt[0]), 32'h0);
      chk("ts_rd_rvalid", 32'(d1_rvalid[0]), 32'h1);
      chk("ts_rd_rid", 32'(d1_rid[0]), 32'h7);
      chk("ts_rd_old", d1_rdata[0], 32'h0);
      tick();
      mid();
      chk("ts_idle_req", 32'(d1_mreq[0]), 32'h0);
      chk("ts_wr_no_resp", 32'(d1_rvalid[0]), 32'h0);
      chk("ts_lat2_rvalid", 32'(d2_rvalid[0]), 32'h1);
      chk("ts_lat2_rdata", d2_rdata[0], 32'h0);
      tick();
      drive(1, 1, 1, 12'h010, '0, 4'hF, 20'h8, 1);
      tick();
      drive(0, 0, 0, '0, '0, '0, '0, 1);
      mid();
      chk("ts2_rvalid", 32'(d1_rvalid[0]), 32'h1);
      chk("ts2_rid", 32'(d1_rid[0]), 32'h8);
      chk("ts2_rdata", d1_rdata[0], 32'hFFFF_FFFF);
      repeat (3) tick();

      // TS write stalled by memory: crossbar request waits for IDLE.
      drive(1, 1, 1, 12'h030, '0, 4'hF, 20'h9, 1);
      tick();
      drive(1, 0, 0, 12'h031, 32'h11, 4'hF, 20'hA, 0);
      for (int c = 0; c < 3; c++) begin
         mid();
         chk($sformatf("stall%0d_gnt", c), 32'(d1_xb_gnt[0]), 32'h0);
         chk($sformatf("stall%0d_add", c), 32'(d1_madd[0]), 32'h030);
         chk($sformatf("stall%0d_wdata", c), d1_mwdata[0], 32'hFFFF_FFFF);
         tick();
      end
      mem_gnt[0] = 1;
      mid();
      chk("stall_release_gnt", 32'(d1_xb_gnt[0]), 32'h0);
      tick();
      mid();
      chk("served_gnt", 32'(d1_xb_gnt[0]), 32'h1);
      chk("served_add", 32'(d1_madd[0]), 32'h031);
      chk("served_wen", 32'(d1_mwen[0]), 32'h0);
      chk("served_wdata", d1_mwdata[0], 32'h11);
      tick();
      drive(0, 0, 0, '0, '0, '0, '0, 1);
      mid();
      chk("served_rvalid", 32'(d1_rvalid[0]), 32'h1);
      chk("served_rid", 32'(d1_rid[0]), 32'hA);
      repeat (3) tick();

      // Four back-to-back writes, ids 1..4.
      drive(1, 0, 0, 12'h060, 32'h1, 4'hF, 20'h1, 1);
      tick();
      for (int k = 1; k <= 4; k++) begin
         if (k < 4) drive(1, 0, 0, 12'(12'h060 + k), 32'(k + 1), 4'hF, 20'(k + 1), 1);
         else       drive(0, 0, 0, '0, '0, '0, '0, 1);
         mid();
         chk($sformatf("b2b%0d_rvalid", k), 32'(d1_rvalid[0]), 32'h1);
         chk($sformatf("b2b%0d_rid", k), 32'(d1_rid[0]), 32'(k));
         tick();
      end
      mid();
      chk("b2b_end_rvalid", 32'(d1_rvalid[0]), 32'h0);
      tick();

      // Reset while in TS write aborts it.
      drive(1, 1, 1, 12'h040, '0, 4'hF, 20'hB, 1);
      tick();
      drive(0, 0, 0, '0, '0, '0, '0, 0);
      rst = 1;
      mid();
      chk("rst_ts_in_write", 32'(d1_mreq[0]), 32'h1);
      tick();
      rst = 0;
      mid();
      chk("rst_ts_req_follow", 32'(d1_mreq[0]), 32'h0);
      chk("rst_ts_rvalid", 32'(d1_rvalid[0]), 32'h0);
      chk("rst_ts_rvalid_lat2", 32'(d2_rvalid[0]), 32'h0);
      chk("rst_ts_rid", 32'(d1_rid[0]), 32'h0);
      tick();
      drive(1, 0, 1, 12'h041, 32'h5, 4'h2, 20'hC, 0);
      mid();
      chk("rst_ts_wen", 32'(d1_mwen[0]), 32'h1);
      chk("rst_ts_add", 32'(d1_madd[0]), 32'h041);
      chk("rst_ts_be", 32'(d1_mbe[0]), 32'h2);

      // Conflict statistics: request held without grant.
`ifdef HCI_LOG_BANK_STATS_EN
      repeat (70000) tick();
      mid();
      chk("stats_saturated", 32'(d1_stats[0]), 32'hFFFF);
      chk("stats_idle_bank", 32'(d1_stats[1]), 32'h0);
`else
      repeat (20) tick();
      mid();
      chk("stats_tied_zero", 32'(d1_stats[0]), 32'h0);
      chk("stats_tied_zero_lat2", 32'(d2_stats[0]), 32'h0);
`endif
      tick();
      drive(0, 0, 0, '0, '0, '0, '0, 0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
